stack_unit: RTL
===============

Name: stack_unit

Overview:
- Hardware LIFO operand stack for the stack-machine multicycle datapath.
- Responder to the controller's Push/Pop/tos commands: stores the word from the memory/ALU mux (MtoS path) on push, and returns the top element on pop or tos into a registered output that feeds the A/B operand latches.
- One command per cycle; sticky error flags report overflow and underflow.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 16, number of stack entries; must be a power of 2, ≥ 2.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-low; sampled on rising clk edge.
- push  in  1  write din on top of the stack.
- pop  in  1  remove top element, copy it to dout.
- tos  in  1  copy top element to dout without removing it.
- din  in  WIDTH  data to push.
- clr_err  in  1  clear the ovf/unf sticky flags.
- dout  out  WIDTH  registered top-of-stack read data.
- count  out  log2(DEPTH)+1  number of valid entries, 0..DEPTH.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.
- ovf  out  1  sticky: push attempted while full.
- unf  out  1  sticky: pop or tos attempted while empty.

Behaviour:
- State: storage array mem[0..DEPTH-1]; stack pointer sp (log2(DEPTH)+1 bits) = count; top entry is mem[sp-1].
- All updates happen on the rising clk edge. count, empty and full decode combinationally from sp.
- Reset (rst==0 at edge):
  - sp=0, dout=0, ovf=0, unf=0.
  - mem contents are not cleared.
  - Reset overrides every command in that cycle.
- push only, not full: mem[sp]<=din, sp<=sp+1; dout unchanged.
- push only, full: no change to mem/sp/dout; ovf<=1.
- pop only, not empty: dout<=mem[sp-1], sp<=sp-1.
- pop only, empty: sp and dout unchanged; unf<=1.
- tos only, not empty: dout<=mem[sp-1]; sp unchanged.
- tos only, empty: dout unchanged; unf<=1.
- push+pop, not empty (replace top):
  - dout<=old top, mem[sp-1]<=din, sp unchanged.
  - ovf is never set, including when full.
- push+pop, empty:
  - push executes: mem[0]<=din, sp<=1, dout unchanged.
  - unf<=1.
- tos+pop: behaves as pop.
- tos+push, not empty: dout<=old top (pre-push) and the push executes; when full, dout<=top, push is dropped, ovf<=1.
- tos+push, empty: push executes, dout unchanged, unf<=1.
- push+pop+tos: behaves as push+pop.
- Latency:
  - Read data on dout is valid the cycle after the command edge and holds until the next successful pop/tos or reset.
  - A pushed value is readable by a pop/tos issued in the very next cycle.
- Pointer never wraps: sp is clamped to 0..DEPTH by the full/empty rules above.
- Error flags:
  - clr_err at an edge clears ovf and unf.
  - If a new error occurs in the same cycle as clr_err, the set wins for that flag.
  - Flags have no effect on stack operation.
- No command asserted: all state holds.

Test Plan:
- Reset then idle: drive rst=0 one edge, release -> dout=0, count=0, empty=1, full=0, ovf=unf=0.
- Push 0x11, 0x22, 0x33; tos; pop x3 -> after tos dout=0x33, count=3; pops give dout=0x33, 0x22, 0x11; count ends 0, empty=1.
- Push 16 values 0x00..0x0F, then push 0xAA -> full=1 after 16th push; 17th push leaves count=16, ovf=1; pop returns 0x0F, not 0xAA.
- On empty stack: pop, then tos -> unf=1, dout unchanged, count=0; then clr_err with no command -> unf=0; then clr_err together with pop -> unf=1.
- Push 0x05, then push+pop with din=0x09 -> dout=0x05, count=1; following pop -> dout=0x09, count=0.
- Push 3 values, assert rst=0 together with push=1 -> count=0, dout=0, flags 0; next push 0x44 then pop -> dout=0x44.

Source files
------------

// File: rtl/stack_if.sv
// stack_if: command/response bundle between the stack-machine controller and the operand stack.
// Ports (signals):
//   push, pop, tos, clr_err  controller -> stack commands
//   din                      word to push (MtoS mux)
//   dout                     registered top-of-stack read data
//   count, empty, full       occupancy status
//   ovf, unf                 sticky overflow / underflow flags
interface stack_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic             push;
    logic             pop;
    logic             tos;
    logic             clr_err;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             ovf;
    logic             unf;
    modport master (output push, pop, tos, clr_err, din,
                    input  dout, count, empty, full, ovf, unf);
    modport slave  (input  push, pop, tos, clr_err, din,
                    output dout, count, empty, full, ovf, unf);
endinterface

// File: rtl/stack_unit.sv
// stack_unit: LIFO operand stack with registered top-of-stack output and sticky error flags.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-low reset
//   bus  stack_if.slave: push/pop/tos/clr_err/din in; dout/count/empty/full/ovf/unf out
module stack_unit #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic    clk,
    input  logic    rst,
    stack_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] SP_ONE  = (AW+1)'(1);
    localparam logic [AW:0] SP_FULL = (AW+1)'(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      sp_q, sp_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             ovf_q, ovf_d, unf_q, unf_d;
    logic             empty, full, replace, wr_push, rd_ok, we;
    logic [AW-1:0]    top_a, wr_a;
    always_comb begin
        empty   = sp_q == '0;
        full    = sp_q == SP_FULL;
        top_a   = AW'(sp_q - SP_ONE);
        // push+pop on a non-empty stack overwrites the top in place
        replace = bus.push & bus.pop & ~empty;
        // a real push: not full, and either no pop or the stack is empty (pop has nothing to take)
        wr_push = bus.push & ~full & (~bus.pop | empty);
        rd_ok   = (bus.pop | bus.tos) & ~empty;
        we      = rst & (wr_push | replace);
        wr_a    = replace ? top_a : sp_q[AW-1:0];
        sp_d    = wr_push ? sp_q + SP_ONE :
                  (bus.pop & ~bus.push & ~empty) ? sp_q - SP_ONE : sp_q;
        dout_d  = rd_ok ? mem_q[top_a] : dout_q;
        // a new error in the same cycle as clr_err wins
        ovf_d   = (bus.push & ~bus.pop & full) | (ovf_q & ~bus.clr_err);
        unf_d   = ((bus.pop | bus.tos) & empty) | (unf_q & ~bus.clr_err);
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            sp_q   <= '0;
            dout_q <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            sp_q   <= sp_d;
            dout_q <= dout_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
        end
    end
    // storage is deliberately not reset
    always_ff @(posedge clk) begin
        if (we) mem_q[wr_a] <= bus.din;
    end
    assign bus.dout  = dout_q;
    assign bus.count = sp_q;
    assign bus.empty = empty;
    assign bus.full  = full;
    assign bus.ovf   = ovf_q;
    assign bus.unf   = unf_q;
endmodule
